// File: rtl/hazard_track_pkg.sv
// Shared pipeline types for hazard tracking: Tuse/Tnew encodings and the
// per-stage {a3, we, tnew} record.
package hazard_track_pkg;

   typedef logic [1:0] tval_t;

   localparam tval_t TUSE_NONE = 2'd3;
   localparam tval_t TNEW_ZERO = 2'd0;
   localparam tval_t TNEW_ALU  = 2'd1;
   localparam tval_t TNEW_LOAD = 2'd2;

   typedef struct packed {
      logic [4:0] a3;
      logic       we;
      tval_t      tnew;
   } stage_rec_t;

   localparam stage_rec_t BUBBLE = '{a3: 5'd0, we: 1'b0, tnew: TNEW_ZERO};

   // One stage of progress toward the result, never going below zero.
   function automatic tval_t tnew_dec(tval_t t);
      return (t == TNEW_ZERO) ? TNEW_ZERO : t - 2'd1;
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Hazard check for one D-stage source against the E and M producer records.
module hazard_cmp
   import hazard_track_pkg::*;
(
   input  logic [4:0] a,
   input  logic [1:0] tuse,
   input  stage_rec_t e_rec,
   input  stage_rec_t m_rec,
   output logic       hazard
);

   logic e_hit;
   logic m_hit;

   assign e_hit  = e_rec.we && (e_rec.a3 == a) && (e_rec.tnew > tuse);
   assign m_hit  = m_rec.we && (m_rec.a3 == a) && (m_rec.tnew > tuse);
   assign hazard = (a != 5'd0) && (e_hit || m_hit);

endmodule

// File: rtl/hazard_track.sv
// Carries destination/write-enable/Tnew through E, M and W, raises the D-stage
// stall and counts stalled cycles.
module hazard_track
   import hazard_track_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       D_a1,
   input  logic [4:0]       D_a2,
   input  logic [1:0]       D_tuse1,
   input  logic [1:0]       D_tuse2,
   input  logic [4:0]       D_a3,
   input  logic             D_we,
   input  logic [1:0]       D_tnew,
   output logic             stall,
   output logic [4:0]       E_a3,
   output logic [4:0]       M_a3,
   output logic [4:0]       W_a3,
   output logic             E_we,
   output logic             M_we,
   output logic             W_we,
   output logic [1:0]       E_tnew,
   output logic [1:0]       M_tnew,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_rec_t       e_q;
   stage_rec_t       m_q;
   logic [4:0]       w_a3_q;
   logic             w_we_q;
   logic [CNT_W-1:0] cnt_q;
   logic             haz1;
   logic             haz2;

   hazard_cmp u_cmp1 (
      .a      (D_a1),
      .tuse   (D_tuse1),
      .e_rec  (e_q),
      .m_rec  (m_q),
      .hazard (haz1)
   );

   hazard_cmp u_cmp2 (
      .a      (D_a2),
      .tuse   (D_tuse2),
      .e_rec  (e_q),
      .m_rec  (m_q),
      .hazard (haz2)
   );

   assign stall = haz1 | haz2;

   // M and W advance every cycle; only the E slot sees the bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q    <= BUBBLE;
         m_q    <= BUBBLE;
         w_a3_q <= 5'd0;
         w_we_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         e_q    <= stall ? BUBBLE : '{a3: D_a3, we: D_we, tnew: D_tnew};
         m_q    <= '{a3: e_q.a3, we: e_q.we, tnew: tnew_dec(e_q.tnew)};
         w_a3_q <= m_q.a3;
         w_we_q <= m_q.we;
         if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
         end
      end
   end

   assign E_a3      = e_q.a3;
   assign E_we      = e_q.we;
   assign E_tnew    = e_q.tnew;
   assign M_a3      = m_q.a3;
   assign M_we      = m_q.we;
   assign M_tnew    = m_q.tnew;
   assign W_a3      = w_a3_q;
   assign W_we      = w_we_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_track.sv
// Scoreboard bench for hazard_track: an age-based model of the in-flight
// instructions predicts each cycle's outputs; a negedge monitor compares.
module tb_hazard_track;

   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    D_a1, D_a2, D_a3;
   logic [1:0]    D_tuse1, D_tuse2, D_tnew;
   logic          D_we;
   logic          stall;
   logic [4:0]    E_a3, M_a3, W_a3;
   logic          E_we, M_we, W_we;
   logic [1:0]    E_tnew, M_tnew;
   logic [CW-1:0] stall_cnt;

   hazard_track #(.CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .D_a1      (D_a1),
      .D_a2      (D_a2),
      .D_tuse1   (D_tuse1),
      .D_tuse2   (D_tuse2),
      .D_a3      (D_a3),
      .D_we      (D_we),
      .D_tnew    (D_tnew),
      .stall     (stall),
      .E_a3      (E_a3),
      .M_a3      (M_a3),
      .W_a3      (W_a3),
      .E_we      (E_we),
      .M_we      (M_we),
      .W_we      (W_we),
      .E_tnew    (E_tnew),
      .M_tnew    (M_tnew),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a3;
      int we;
      int tnew;
   } rec_t;

   typedef struct {
      int stall;
      int e_a3, e_we, e_tnew;
      int m_a3, m_we, m_tnew;
      int w_a3, w_we;
      int cnt;
   } exp_t;

   rec_t slots[$];  // slots[k]: what entered E k+1 edges ago (bubble or instruction)
   int   cnt_m;
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(string name, int act, int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      rec_t z = '{0, 0, 0};
      slots.delete();
      repeat (3) slots.push_back(z);
      cnt_m = 0;
   endtask

   function automatic int src_hazard(int a, int tuse);
      int rem;
      if (a == 0) return 0;
      for (int k = 0; k < 2; k++) begin
         rem = slots[k].tnew - k;
         if (rem < 0) rem = 0;
         if (slots[k].we != 0 && slots[k].a3 == a && rem > tuse) return 1;
      end
      return 0;
   endfunction

   function automatic exp_t model_exp(int s);
      exp_t x;
      x.stall  = s;
      x.e_a3   = slots[0].a3;
      x.e_we   = slots[0].we;
      x.e_tnew = slots[0].tnew;
      x.m_a3   = slots[1].a3;
      x.m_we   = slots[1].we;
      x.m_tnew = (slots[1].tnew > 0) ? slots[1].tnew - 1 : 0;
      x.w_a3   = slots[2].a3;
      x.w_we   = slots[2].we;
      x.cnt    = cnt_m;
      return x;
   endfunction

   task automatic step(int a1, int t1, int a2, int t2, int a3, int we, int tn);
      exp_t x;
      rec_t d;
      rec_t z = '{0, 0, 0};
      int   s;
      D_a1    = 5'(a1);
      D_tuse1 = 2'(t1);
      D_a2    = 5'(a2);
      D_tuse2 = 2'(t2);
      D_a3    = 5'(a3);
      D_we    = 1'(we);
      D_tnew  = 2'(tn);
      s = src_hazard(a1, t1) | src_hazard(a2, t2);
      x = model_exp(s);
      sb.push_back(x);
      @(posedge clk);
      d = '{a3, we, tn};
      slots.push_front(s != 0 ? z : d);
      void'(slots.pop_back());
      if (s != 0 && cnt_m < CMAX) cnt_m++;
      #1;
   endtask

   task automatic clear_d();
      D_a1 = 0; D_a2 = 0; D_a3 = 0;
      D_tuse1 = 2'd3; D_tuse2 = 2'd3; D_tnew = 0; D_we = 0;
   endtask

   // Called at posedge+1; reset pulse lies entirely between edges.
   task automatic do_reset();
      clear_d();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      model_reset();
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t x;
         x = sb.pop_front();
         chk("sb_stall", int'(stall), x.stall);
         chk("sb_e_a3", int'(E_a3), x.e_a3);
         chk("sb_e_we", int'(E_we), x.e_we);
         chk("sb_e_tnew", int'(E_tnew), x.e_tnew);
         chk("sb_m_a3", int'(M_a3), x.m_a3);
         chk("sb_m_we", int'(M_we), x.m_we);
         chk("sb_m_tnew", int'(M_tnew), x.m_tnew);
         chk("sb_w_a3", int'(W_a3), x.w_a3);
         chk("sb_w_we", int'(W_we), x.w_we);
         chk("sb_cnt", int'(stall_cnt), x.cnt);
      end
   end

   initial begin
      reset = 1'b1;
      clear_d();
      D_tuse1 = 0; D_tuse2 = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state, all D inputs zero
      chk("rst_stall", int'(stall), 0);
      chk("rst_e", int'({E_a3, E_we, E_tnew}), 0);
      chk("rst_m", int'({M_a3, M_we, M_tnew}), 0);
      chk("rst_w", int'({W_a3, W_we}), 0);
      chk("rst_cnt", int'(stall_cnt), 0);
      repeat (10) step(0, 0, 0, 0, 0, 0, 0);

      // Load-use: one stall, bubble in E, lw reaches W as add enters E
      do_reset();
      step(0, 3, 0, 3, 1, 1, 2);
      step(1, 1, 0, 3, 4, 1, 1);
      chk("lu_bubble_we", int'(E_we), 0);
      step(1, 1, 0, 3, 4, 1, 1);
      chk("lu_w_a3", int'(W_a3), 1);
      chk("lu_e_a3", int'(E_a3), 4);
      chk("lu_cnt", int'(stall_cnt), 1);

      // Load-branch: two stalls
      do_reset();
      step(0, 3, 0, 3, 2, 1, 2);
      step(2, 0, 0, 3, 0, 0, 0);
      step(2, 0, 0, 3, 0, 0, 0);
      chk("lb_release", int'(stall), 0);
      chk("lb_cnt", int'(stall_cnt), 2);
      step(2, 0, 0, 3, 0, 0, 0);

      // ALU producer feeding a store's data source: no stall
      do_reset();
      step(0, 3, 0, 3, 3, 1, 1);
      step(0, 3, 3, 2, 0, 0, 0);
      chk("as_m_a3", int'(M_a3), 3);
      chk("as_m_we", int'(M_we), 1);
      chk("as_m_tnew", int'(M_tnew), 0);
      chk("as_cnt", int'(stall_cnt), 0);

      // Register 0 never stalls
      do_reset();
      step(0, 3, 0, 3, 0, 1, 2);
      step(0, 0, 0, 0, 5, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("r0_cnt", int'(stall_cnt), 0);

      // Asynchronous reset in the middle of a load-branch stall
      do_reset();
      step(0, 3, 0, 3, 2, 1, 2);
      step(2, 0, 0, 3, 0, 0, 0);
      chk("ar_pre_stall", int'(stall), 1);
      chk("ar_pre_cnt", int'(stall_cnt), 1);
      reset = 1'b1;
      #1;
      chk("ar_stall", int'(stall), 0);
      chk("ar_we", int'({E_we, M_we, W_we}), 0);
      chk("ar_cnt", int'(stall_cnt), 0);
      clear_d();
      reset = 1'b0;
      model_reset();

      // Randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 1500; i++) begin
         if (i % 150 == 0) do_reset();
         step($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2));
      end

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
